// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reservations, cleared by writes/flush.
// REGFILE_BYPASS_EN: same-cycle writes mask busy unless a same-cycle reservation re-arms it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic              flush,
  input  logic [NRD-1:0]    rd_en,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [AW-1:0]   busy_sel;

  // Order encodes priority: write clear < reservation set < flush clear.
  always_comb begin
    pending_d = pending_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) pending_d[wr_addr[p*AW +: AW]] = 1'b0;
    end
    if (rsv_en) pending_d[rsv_addr] = 1'b1;
    if (flush)  pending_d = '0;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  always_comb begin
    rd_busy  = '0;
    busy_sel = '0;
    for (int q = 0; q < NRD; q++) begin
      busy_sel   = rd_addr[q*AW +: AW];
      rd_busy[q] = rd_en[q] & pending_q[busy_sel];
`ifdef REGFILE_BYPASS_EN
      if (!(rsv_en && rsv_addr == busy_sel)) begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && wr_addr[p*AW +: AW] == busy_sel) rd_busy[q] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with fixed write priority (port 0 highest).
// Optional REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                flush
);

  logic [XLEN-1:0] mem_q [1:NREG-1];
  logic [XLEN-1:0] mem_d [1:NREG-1];
  logic [AW-1:0]   rd_sel;

  // NOTE: blocking assignments in always_comb; walking ports high-to-low lets port 0 land last and win.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      mem_d[r] = mem_q[r];
      for (int p = NWR - 1; p >= 0; p--) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r)) mem_d[r] = wr_data[p*XLEN +: XLEN];
      end
    end
  end

  // NOTE: the storage array is reset explicitly because zeroed registers are architecturally visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 1; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) mem_q[r] <= mem_d[r];
    end
  end

  always_comb begin
    rd_data = '0;
    rd_sel  = '0;
    for (int q = 0; q < NRD; q++) begin
      rd_sel = rd_addr[q*AW +: AW];
      if (rd_en[q] && rd_sel != AW'(ZERO_REG)) begin
        for (int r = 1; r < NREG; r++) begin
          if (rd_sel == AW'(r)) rd_data[q*XLEN +: XLEN] = mem_q[r];
        end
`ifdef REGFILE_BYPASS_EN
        for (int p = NWR - 1; p >= 0; p--) begin
          if (wr_en[p] && wr_addr[p*AW +: AW] == rd_sel) rd_data[q*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
        end
`endif
      end
    end
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, priority, x0 handling, scoreboard, flush, bypass, async reset.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .flush    (flush)
  );

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int q, input logic en, input reg_idx_t a);
    rd_en[q] = en;
    rd_addr[q*AW +: AW] = a;
  endtask

  task automatic set_wr(input int p, input logic en, input reg_idx_t a, input logic [XLEN-1:0] d);
    wr_en[p] = en;
    wr_addr[p*AW +: AW] = a;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic reserve(input reg_idx_t a);
    rsv_en = 1'b1;
    rsv_addr = a;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    set_rd(0, 1'b1, 5'd5);
    set_rd(1, 1'b1, 5'd31);
    #2;
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_low_data: got %h want 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_low_busy: got %b want 00", rd_busy); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rel_data: got %h want 0", rd_data); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL reset_rel_busy: got %b want 00", rd_busy); end
    tick();
  endtask

  task automatic test_priority();
    idle();
    set_wr(0, 1'b1, 5'd7, 32'hAAAA_0001);
    set_wr(1, 1'b1, 5'd7, 32'h5555_0002);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd7);
    set_rd(1, 1'b1, 5'd7);
    #1;
    n_checks++; if (rd_data[31:0] !== 32'hAAAA_0001) begin n_fail++; $display("FAIL prio_rd0: got %h want aaaa0001", rd_data[31:0]); end
    n_checks++; if (rd_data[63:32] !== 32'hAAAA_0001) begin n_fail++; $display("FAIL prio_rd1: got %h want aaaa0001", rd_data[63:32]); end
    set_wr(1, 1'b1, 5'd10, 32'h5555_0002);
    tick();
    idle();
    set_rd(1, 1'b1, 5'd10);
    #1;
    n_checks++; if (rd_data[63:32] !== 32'h5555_0002) begin n_fail++; $display("FAIL port1_write: got %h want 55550002", rd_data[63:32]); end
  endtask

  task automatic test_zero_and_disable();
    idle();
    set_wr(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    set_wr(1, 1'b1, 5'd3, 32'h0000_0033);
    reserve(5'd0);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd0);
    set_rd(1, 1'b0, 5'd3);
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL x0_read: got %h want 0", rd_data[31:0]); end
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %b want 0", rd_busy[0]); end
    n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL rd_en_off: got %h want 0", rd_data[63:32]); end
    set_rd(1, 1'b1, 5'd3);
    #1;
    n_checks++; if (rd_data[63:32] !== 32'h0000_0033) begin n_fail++; $display("FAIL x3_enabled: got %h want 33", rd_data[63:32]); end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    reserve(5'd9);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd9);
    #1;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rsv_busy: got %b want 1", rd_busy[0]); end
    set_rd(1, 1'b0, 5'd9);
    #1;
    n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL busy_rd_en_off: got %b want 0", rd_busy[1]); end
    set_wr(1, 1'b1, 5'd9, 32'h0000_1234);
    #1;
    n_checks++; if (rd_busy[0] !== !BYP) begin n_fail++; $display("FAIL busy_write_cycle: got %b want %b", rd_busy[0], !BYP); end
    tick();
    idle();
    set_rd(0, 1'b1, 5'd9);
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL wr_clears_busy: got %b want 0", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'h0000_1234) begin n_fail++; $display("FAIL wr_data_x9: got %h want 1234", rd_data[31:0]); end
    reserve(5'd9);
    set_wr(1, 1'b1, 5'd9, 32'h0000_5678);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd9);
    #1;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rsv_beats_wr: got %b want 1", rd_busy[0]); end
    n_checks++; if (rd_data[31:0] !== 32'h0000_5678) begin n_fail++; $display("FAIL rsv_wr_data: got %h want 5678", rd_data[31:0]); end
    reserve(5'd9);
    set_wr(0, 1'b1, 5'd9, 32'h0000_9ABC);
    #1;
    n_checks++; if (rd_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rsv_wr_same_cycle_busy: got %b want 1", rd_busy[0]); end
    tick();
    idle();
    set_wr(0, 1'b1, 5'd9, 32'h0000_9ABC);
    tick();
    idle();
  endtask

  task automatic test_flush();
    idle();
    reserve(5'd4);
    tick();
    reserve(5'd6);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd4);
    set_rd(1, 1'b1, 5'd6);
    #1;
    n_checks++; if (rd_busy !== 2'b11) begin n_fail++; $display("FAIL pre_flush_busy: got %b want 11", rd_busy); end
    flush = 1'b1;
    reserve(5'd8);
    set_wr(0, 1'b1, 5'd20, 32'h0000_F1F1);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd4);
    set_rd(1, 1'b1, 5'd6);
    #1;
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL flush_x4_x6: got %b want 00", rd_busy); end
    set_rd(0, 1'b1, 5'd8);
    set_rd(1, 1'b1, 5'd20);
    #1;
    n_checks++; if (rd_busy[0] !== 1'b0) begin n_fail++; $display("FAIL flush_beats_rsv: got %b want 0", rd_busy[0]); end
    n_checks++; if (rd_data[63:32] !== 32'h0000_F1F1) begin n_fail++; $display("FAIL flush_write_commits: got %h want f1f1", rd_data[63:32]); end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    set_wr(0, 1'b1, 5'd12, 32'h0000_1111);
    tick();
    idle();
    set_wr(0, 1'b1, 5'd12, 32'hDEAD_BEEF);
    set_wr(1, 1'b1, 5'd12, 32'hBAD0_BAD0);
    set_rd(0, 1'b1, 5'd12);
    set_rd(1, 1'b1, 5'd12);
    #1;
    n_checks++; if (rd_data[31:0] !== (BYP ? 32'hDEAD_BEEF : 32'h0000_1111)) begin n_fail++; $display("FAIL bypass_rd0: got %h bypass=%0d", rd_data[31:0], BYP); end
    n_checks++; if (rd_data[63:32] !== (BYP ? 32'hDEAD_BEEF : 32'h0000_1111)) begin n_fail++; $display("FAIL bypass_rd1: got %h bypass=%0d", rd_data[63:32], BYP); end
    tick();
    idle();
    set_rd(0, 1'b1, 5'd12);
    #1;
    n_checks++; if (rd_data[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL after_bypass: got %h want deadbeef", rd_data[31:0]); end
  endtask

  task automatic test_async_reset();
    idle();
    set_wr(0, 1'b1, 5'd15, 32'h1515_1515);
    reserve(5'd16);
    tick();
    idle();
    set_rd(0, 1'b1, 5'd15);
    set_rd(1, 1'b1, 5'd16);
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h1515_1515) begin n_fail++; $display("FAIL pre_areset_data: got %h want 15151515", rd_data[31:0]); end
    n_checks++; if (rd_busy[1] !== 1'b1) begin n_fail++; $display("FAIL pre_areset_busy: got %b want 1", rd_busy[1]); end
    set_wr(0, 1'b1, 5'd15, 32'h0000_0099);
    #1;
    reset = 1'b0;
    #1;
    n_checks++; if (rd_data[31:0] !== (BYP ? 32'h0000_0099 : 32'h0)) begin n_fail++; $display("FAIL areset_immediate: got %h bypass=%0d", rd_data[31:0], BYP); end
    n_checks++; if (rd_busy[1] !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", rd_busy[1]); end
    tick();
    idle();
    set_rd(0, 1'b1, 5'd15);
    set_rd(1, 1'b1, 5'd16);
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL areset_write_lost: got %h want 0", rd_data[31:0]); end
    n_checks++; if (rd_busy !== 2'b00) begin n_fail++; $display("FAIL areset_busy_after: got %b want 00", rd_busy); end
    tick();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_zero_and_disable();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core. It replaces the fixed two-read/two-write file with configurable XLEN, register count, read-port count and write-port count, using fixed write-port priority. It adds a pending-write scoreboard so issue logic can stall on registers awaiting long-latency (MAU/load) writeback. It sits between decode/issue (read ports, reservations) and the ALU/MAU writeback paths (write ports).

## Interface
- XLEN, 32, data width in bits
- NREG, 32, architectural register count (power of two, ≥2); AW = $clog2(NREG) derived locally
- NRD, 2, read-port count (1..4)
- NWR, 2, write-port count (1..4); port 0 is the highest priority
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  per-port destination index; port p occupies bits [p*AW +: AW]
- wr_data  in  NWR*XLEN  per-port write data
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  per-port source index
- rd_data  out  NRD*XLEN  per-port read data
- rd_busy  out  NRD  per-port flag: the source register has a pending write
- rsv_en  in  1  reserve a destination (load issued)
- rsv_addr  in  AW  register index to mark pending
- flush  in  1  synchronous clear of all pending bits (pipeline flush)

## Operation
- Storage: registers 1..NREG-1. Register 0 has no storage. Reads of index 0 return 0. Writes to index 0 are dropped.
- Write: on a clk rising edge, each register r takes wr_data of the lowest-numbered port p with wr_en[p]=1 and wr_addr[p]=r. Lower-numbered ports always beat higher-numbered ports; no error is flagged.
- Read (combinational): rd_data[q] = 0 if rd_en[q]=0 or rd_addr[q]=0; otherwise the stored value, subject to the bypass rule in Configuration.
- Scoreboard: one pending bit per register; bit 0 is constant 0.
  - Any accepted write to r (any port) clears pending[r].
  - rsv_en=1 sets pending[rsv_addr]. If a reservation and a write to the same r occur in the same cycle, the reservation wins and pending[r] ends at 1.
  - flush=1 clears every pending bit and also overrides rsv_en in the same cycle. Writes still commit data during flush.
- rd_busy[q] = rd_en[q] & pending[rd_addr[q]]. It is 0 for index 0. It does not take same-cycle clears into account.

## Timing
- Reset: all registers 0 and all pending bits 0. As a result, rd_data = 0 and rd_busy = 0 for every port while reset is low and immediately after it is released.
- A reset assertion in the middle of a cycle clears state immediately. Writes in that cycle are lost.
- Read latency: 0 cycles, combinational from rd_addr/rd_en.
- Write latency: 1 cycle; the value is visible to reads after the edge.
- Scoreboard update: 1 cycle. A pending bit set at edge N shows on rd_busy after edge N. A write at edge M clears it after edge M.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read of r ≠ 0 in the same cycle as an enabled write to r returns the winning port's wr_data combinationally.
  - rd_busy for that r also reads 0 in that cycle, unless rsv_en targets the same r.
- REGFILE_BYPASS_EN undefined:
  - Reads return the pre-edge stored value.
  - rd_busy reflects the stored pending bit only.

## Structure
- regfile_pkg holds:
  - XLEN_DEF = 32 and NREG_DEF = 32
  - the reg_idx_t typedef (logic [4:0])
  - the ZERO_REG constant
- Sub-module regfile_scoreboard: contains the pending-bit array, set/clear/flush priority and per-port busy lookup. It is parametrised by NREG, NRD and NWR.

## Test plan
- Reset then read x5, x31 on both ports → rd_data = 0, rd_busy = 0.
- Port0 writes x7=0xAAAA_0001 and port1 writes x7=0x5555_0002 in the same cycle; read x7 next cycle → 0xAAAA_0001.
- Write x0=0xFFFF_FFFF; read x0 with rd_en=1 → 0. Read x3 with rd_en=0 → 0.
- rsv_en to x9; next cycle read x9 → rd_busy=1. Port1 writes x9=0x1234 → one cycle later rd_busy=0 and rd_data=0x1234. Repeat with rsv_en and the write in the same cycle → rd_busy stays 1.
- Reserve x4 and x6, then assert flush together with rsv_en x8 → next cycle busy=0 for x4, x6 and x8.
- With REGFILE_BYPASS_EN: read x12 while port0 writes x12=0xDEAD_BEEF → rd_data=0xDEAD_BEEF in the same cycle. Without the macro → old value, and 0xDEAD_BEEF the next cycle.
